shared_reg_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit register bank among N_REQ requesters.
- The bank is built from d_flop_enable_and_clear cells, one per bit, sharing clk.
- This block drives the bank's shared enable, active-low clear and data input.
- Requesters issue single-cycle writes or clears, or lock the register for bounded multi-cycle ownership.

---
 rtl/shared_reg_arbiter_if.sv | 29 ++
 rtl/shared_reg_arbiter.sv | 121 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesters and the shared register arbiter.
// The slave side is the arbiter. It drives the grant and the bank controls.
interface shared_reg_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ-1:0]       clr_req;
    logic [N_REQ*WIDTH-1:0] wr_data;
    logic [N_REQ-1:0]       gnt;
    logic [IDW-1:0]         gnt_id;
    logic                   flop_en;
    logic                   flop_clear_n;
    logic [WIDTH-1:0]       flop_din;
    logic                   timeout;

    modport master (
        output req, lock, clr_req, wr_data,
        input  gnt, gnt_id, flop_en, flop_clear_n, flop_din, timeout
    );

    modport slave (
        input  req, lock, clr_req, wr_data,
        output gnt, gnt_id, flop_en, flop_clear_n, flop_din, timeout
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and sequencer for one shared WIDTH-bit register bank.
// Requesters issue single-cycle writes or clears. A requester can also lock the bank
// for up to MAX_HOLD consecutive cycles. All outputs are registered, so the bank
// captures one edge after the decision.
module shared_reg_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic                clk,
    input logic                reset,
    shared_reg_arbiter_if.slave bus
);
    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // hold_cnt only has to reach MAX_HOLD-1
    localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HoldLast = HCW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StSingle, StLocked} state_e;

    state_e             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [HCW-1:0]     hold_cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [IDW-1:0]     gnt_id_q;
    logic               flop_en_q;
    logic               flop_clear_n_q;
    logic [WIDTH-1:0]   flop_din_q;
    logic               timeout_q;

    logic               keep_owner;
    logic               force_rel;
    logic               scan_found;
    logic [IDW-1:0]     scan_win;
    logic [IDW-1:0]     scan_cand;
    logic               grant_valid;
    logic [IDW-1:0]     sel;

    // Decide whether the lock owner keeps the bank or the lock is forced to end.
    always_comb begin
        keep_owner = 1'b0;
        force_rel  = 1'b0;
        if (state_q == StLocked && bus.req[gnt_id_q] && bus.lock[gnt_id_q]) begin
            if (hold_cnt_q < HoldLast) begin
                keep_owner = 1'b1;
            end else begin
                force_rel = 1'b1;
            end
        end
    end

    // Round-robin scan from rr_ptr, wrapping from N_REQ-1 to 0. The first set request wins.
    always_comb begin
        scan_found = 1'b0;
        scan_win   = '0;
        scan_cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_cand = IDW'((32'(rr_ptr_q) + i) % N_REQ);
            if (!scan_found && bus.req[scan_cand]) begin
                scan_found = 1'b1;
                scan_win   = scan_cand;
            end
        end
    end

    // Pick the winner. A continuing lock owner takes priority over the scan.
    always_comb begin
        grant_valid = keep_owner | scan_found;
        sel         = keep_owner ? gnt_id_q : scan_win;
    end

    // Sequencer state and registered bank controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            hold_cnt_q     <= '0;
            gnt_q          <= '0;
            gnt_id_q       <= '0;
            flop_en_q      <= 1'b0;
            flop_clear_n_q <= 1'b1;
            flop_din_q     <= '0;
            timeout_q      <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (grant_valid) begin
                gnt_q    <= N_REQ'(1) << sel;
                gnt_id_q <= sel;
                // Clear wins over write. flop_din keeps its value during a clear.
                if (bus.clr_req[sel]) begin
                    flop_en_q      <= 1'b0;
                    flop_clear_n_q <= 1'b0;
                end else begin
                    flop_en_q      <= 1'b1;
                    flop_clear_n_q <= 1'b1;
                    flop_din_q     <= bus.wr_data[32'(sel) * WIDTH +: WIDTH];
                end
                if (keep_owner) begin
                    hold_cnt_q <= hold_cnt_q + HCW'(1);
                end else begin
                    rr_ptr_q   <= IDW'((32'(sel) + 1) % N_REQ);
                    hold_cnt_q <= '0;
                    state_q    <= (bus.lock[sel] && (MAX_HOLD > 1)) ? StLocked : StSingle;
                end
            end else begin
                state_q        <= StIdle;
                hold_cnt_q     <= '0;
                gnt_q          <= '0;
                flop_en_q      <= 1'b0;
                flop_clear_n_q <= 1'b1;
            end
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.gnt_id       = gnt_id_q;
    assign bus.flop_en      = flop_en_q;
    assign bus.flop_clear_n = flop_clear_n_q;
    assign bus.flop_din     = flop_din_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios followed by random traffic.
// A local register stands in for the bank. Expectations come from a tenure-based model.
module tb_shared_reg_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic [W-1:0] bank_q = '0;

    int n_chk = 0;
    int n_err = 0;
    string phase = "init";

    // Model state: the current owner and how many cycles it has held the bank so far.
    int       m_rr;
    int       m_owner;
    int       m_tenure;
    bit       m_locked;
    logic [N-1:0] e_gnt;
    int       e_id;
    bit       e_en, e_clrn, e_to;
    logic [W-1:0] e_din;
    logic [W-1:0] e_bank = '0;

    shared_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Bank of enable-and-clear flops driven by the arbiter.
    always @(posedge clk) begin
        if (!bus.flop_clear_n) bank_q <= '0;
        else if (bus.flop_en) bank_q <= bus.flop_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) == N'(1);
    endfunction

    task automatic model_reset();
        m_rr = 0; m_owner = 0; m_tenure = 0; m_locked = 0;
        e_gnt = '0; e_id = 0; e_en = 0; e_clrn = 1; e_din = '0; e_to = 0;
    endtask

    function automatic void bank_update();
        if (!e_clrn) e_bank = '0;
        else if (e_en) e_bank = e_din;
    endfunction

    task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] lk,
                              input logic [N-1:0] cl, input logic [N*W-1:0] wd);
        int win;
        bit cont;
        bank_update();
        e_to = 0; cont = 0; win = -1;
        if (m_locked && bit_at(rq, m_owner) && bit_at(lk, m_owner)) begin
            if (m_tenure < MH) begin
                cont = 1; win = m_owner; m_tenure++;
            end else begin
                e_to = 1;
            end
        end
        if (!cont) begin
            for (int k = 0; k < N; k++)
                if (win < 0 && bit_at(rq, (m_rr + k) % N)) win = (m_rr + k) % N;
            if (win >= 0) begin
                m_rr = (win + 1) % N; m_owner = win; m_tenure = 1;
                m_locked = bit_at(lk, win) && (MH > 1);
            end else begin
                m_locked = 0;
            end
        end
        if (win < 0) begin
            e_gnt = '0; e_en = 0; e_clrn = 1;
        end else begin
            e_gnt = N'(1 << win); e_id = win;
            if (bit_at(cl, win)) begin
                e_en = 0; e_clrn = 0;
            end else begin
                e_en = 1; e_clrn = 1; e_din = W'(wd >> (win * W));
            end
        end
    endtask

    task automatic compare_all();
        chk("gnt", 32'(bus.gnt), 32'(e_gnt));
        if (e_gnt != 0) chk("gnt_id", 32'(bus.gnt_id), 32'(e_id));
        chk("flop_en", 32'(bus.flop_en), 32'(e_en));
        chk("flop_clear_n", 32'(bus.flop_clear_n), 32'(e_clrn));
        chk("flop_din", 32'(bus.flop_din), 32'(e_din));
        chk("timeout", 32'(bus.timeout), 32'(e_to));
        chk("bank", 32'(bank_q), 32'(e_bank));
        chk("inv_onehot0", 32'($onehot0(bus.gnt)), 32'(1));
        chk("inv_en_gnt", 32'(!bus.flop_en || (bus.gnt != 0)), 32'(1));
        chk("inv_en_clr", 32'(!(bus.flop_en && !bus.flop_clear_n)), 32'(1));
        chk("inv_clr_gnt", 32'(bus.flop_clear_n || (bus.gnt != 0)), 32'(1));
    endtask

    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic [N-1:0] cl, input logic [N*W-1:0] wd);
        bus.req = rq; bus.lock = lk; bus.clr_req = cl; bus.wr_data = wd;
        @(posedge clk);
        model_step(rq, lk, cl, wd);
        #1;
        compare_all();
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        bank_update();
        model_reset();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        bus.req = '0; bus.lock = '0; bus.clr_req = '0; bus.wr_data = '0;
        reset_cycle();
        reset_cycle();
        reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_g [4];
        logic [W-1:0] exp_d [4];
        logic [N-1:0] r_rq, r_lk, r_cl;
        exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010; exp_g[3] = 4'b1000;
        exp_d[0] = 8'hA5;   exp_d[1] = 8'h3C;   exp_d[2] = 8'hA5;   exp_d[3] = 8'h3C;

        // Idle after reset release.
        phase = "idle";
        apply_reset();
        for (int c = 0; c < 5; c++) step('0, '0, '0, '0);

        // Two requesters alternate writes.
        phase = "alternate";
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            step(4'b1010, '0, '0, 32'h3C00_A500);
            chk("alt_gnt", 32'(bus.gnt), 32'(exp_g[c]));
            chk("alt_din", 32'(bus.flop_din), 32'(exp_d[c]));
            if (c > 0) chk("alt_bank", 32'(bank_q), 32'(exp_d[c-1]));
        end
        step('0, '0, '0, '0);
        chk("alt_bank_last", 32'(bank_q), 32'h3C);

        // A write followed by a clear.
        phase = "clear";
        step(4'b0100, '0, '0, 32'h00FF_0000);
        step(4'b0100, '0, 4'b0100, 32'h0011_0000);
        chk("clr_n", 32'(bus.flop_clear_n), 32'(0));
        chk("clr_bank_ff", 32'(bank_q), 32'hFF);
        step('0, '0, '0, '0);
        chk("clr_bank_00", 32'(bank_q), 32'h00);

        // The lock is forced to end after MAX_HOLD cycles.
        phase = "lock_timeout";
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            step(4'b0011, 4'b0001, '0, 32'h0000_2211);
            if (c < 4) chk("lt_gnt", 32'(bus.gnt), 32'(4'b0001));
            if (c == 4) chk("lt_gnt_new", 32'(bus.gnt), 32'(4'b0010));
            chk("lt_timeout", 32'(bus.timeout), 32'(c == 4));
        end

        // An asynchronous reset in the middle of a lock.
        phase = "async_reset";
        apply_reset();
        step(4'b0001, 4'b0001, '0, 32'h0000_0077);
        step(4'b0001, 4'b0001, '0, 32'h0000_0078);
        #1 reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("ar_gnt_async", 32'(bus.gnt), 32'(0));
        reset_cycle();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(4'b0001, 4'b0001, '0, 32'h0000_0040 + 32'(c));
            chk("ar_gnt", 32'(bus.gnt), 32'(4'b0001));
            chk("ar_timeout", 32'(bus.timeout), 32'(c == 4));
        end

        // A one-cycle request with lock set.
        phase = "pulse";
        step('0, '0, '0, '0);
        step(4'b1000, 4'b1000, '0, 32'h9900_0000);
        chk("pl_gnt", 32'(bus.gnt), 32'(4'b1000));
        step('0, 4'b1000, '0, '0);
        chk("pl_gnt_off", 32'(bus.gnt), 32'(0));
        chk("pl_timeout", 32'(bus.timeout), 32'(0));

        // Random traffic with lock favoured and clears occasional.
        phase = "random";
        for (int c = 0; c < 600; c++) begin
            r_rq = N'($urandom);
            r_lk = N'($urandom | $urandom);
            r_cl = N'($urandom & $urandom & $urandom);
            step(r_rq, r_lk, r_cl, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
